// File: rtl/router_buffered_pkg.sv
// Shared router definitions: port indices, direction enum, small helpers for arbitration and accounting.
// Pure declarations; no logic, no latency, no backpressure of its own.
package router_buffered_pkg;

  localparam int DIRECTIONS = 5;
  localparam int ROUTE_XY   = 0;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  function automatic logic [2:0] wrap_dir(input int v);
    return 3'(v % DIRECTIONS);
  endfunction

  function automatic logic [2:0] popcount_dir(input logic [DIRECTIONS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < DIRECTIONS; k++) c = c + {2'b00, v[k]};
    return c;
  endfunction

endpackage

// File: rtl/router_buffered_fifo.sv
// Per-input flit FIFO; head is combinational from storage, push/pop take effect on the next edge.
// A full FIFO refuses a push even when it pops in the same cycle; o_full comes from the registered count.
module router_buffered_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [FLIT_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/router_buffered.sv
// Input-buffered 5-port mesh router: dimension-order routing, per-output round-robin, windowed activity count.
// Flit injected before edge t is buffered at t and registered on its output at t+1; i_out_busy holds the output register.
module router_buffered
  import router_buffered_pkg::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int COORD_W    = 3,
  parameter int FLIT_W     = 32,
  parameter int DEPTH      = 4,
  parameter int ROUTE_MODE = 0,
  parameter int WIN_LOG2   = 10,
  parameter int CNT_W      = 20
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [DIRECTIONS-1:0]        i_in_valid,
  input  logic [DIRECTIONS*FLIT_W-1:0] i_in_flit,
  output logic [DIRECTIONS-1:0]        o_in_busy,
  output logic [DIRECTIONS-1:0]        o_out_valid,
  output logic [DIRECTIONS*FLIT_W-1:0] o_out_flit,
  input  logic [DIRECTIONS-1:0]        i_out_busy,
  output logic [CNT_W-1:0]             o_flit_counter
);

  localparam logic [COORD_W-1:0] X_C = X_ID[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_C = Y_ID[COORD_W-1:0];

  logic [DIRECTIONS-1:0]                  w_empty;
  logic [DIRECTIONS-1:0]                  w_full;
  logic [DIRECTIONS-1:0]                  w_pop;
  logic [DIRECTIONS-1:0][FLIT_W-1:0]      w_head;
  logic [2:0]                             w_dir [DIRECTIONS];
  logic [DIRECTIONS-1:0][DIRECTIONS-1:0]  w_req;
  logic [DIRECTIONS-1:0]                  w_slot_free;
  logic [DIRECTIONS-1:0]                  w_gnt_vld;
  logic [DIRECTIONS-1:0][2:0]             w_gnt_idx;

  logic [DIRECTIONS-1:0]                  r_out_valid;
  logic [DIRECTIONS-1:0][FLIT_W-1:0]      r_out_flit;
  logic [DIRECTIONS-1:0][2:0]             r_ptr;

  for (genvar gi = 0; gi < DIRECTIONS; gi++) begin : g_in
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    port_e              w_route;

    router_buffered_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_reset),
      .i_push  (i_in_valid[gi]),
      .i_dat   (i_in_flit[gi*FLIT_W +: FLIT_W]),
      .i_pop   (w_pop[gi]),
      .o_head  (w_head[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );

    assign w_dy = w_head[gi][FLIT_W-1 -: COORD_W];
    assign w_dx = w_head[gi][FLIT_W-1-COORD_W -: COORD_W];

    // y grows southward, so a larger dy means the flit still has to travel S.
    always_comb begin
      w_route = PORT_L;
      if (ROUTE_MODE == ROUTE_XY) begin
        if (w_dx > X_C)      w_route = PORT_E;
        else if (w_dx < X_C) w_route = PORT_W;
        else if (w_dy > Y_C) w_route = PORT_S;
        else if (w_dy < Y_C) w_route = PORT_N;
      end else begin
        if (w_dy > Y_C)      w_route = PORT_S;
        else if (w_dy < Y_C) w_route = PORT_N;
        else if (w_dx > X_C) w_route = PORT_E;
        else if (w_dx < X_C) w_route = PORT_W;
      end
    end

    assign w_dir[gi] = w_route;
  end

  always_comb begin
    w_req = '0;
    for (int o = 0; o < DIRECTIONS; o++) begin
      for (int i = 0; i < DIRECTIONS; i++) begin
        w_req[o][i] = !w_empty[i] && (w_dir[i] == 3'(o));
      end
    end
  end

  assign w_slot_free = ~r_out_valid | ~i_out_busy;

  // An input requests exactly one output, so at most one grant can pop it per cycle.
  always_comb begin
    w_pop     = '0;
    w_gnt_vld = '0;
    w_gnt_idx = '0;
    for (int o = 0; o < DIRECTIONS; o++) begin
      for (int k = 0; k < DIRECTIONS; k++) begin
        if (w_slot_free[o] && !w_gnt_vld[o] && w_req[o][wrap_dir(int'(r_ptr[o]) + k)]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = wrap_dir(int'(r_ptr[o]) + k);
        end
      end
      if (w_gnt_vld[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= '0;
      r_out_flit  <= '0;
      r_ptr       <= '0;
    end else begin
      for (int o = 0; o < DIRECTIONS; o++) begin
        if (w_slot_free[o]) begin
          r_out_valid[o] <= w_gnt_vld[o];
          if (w_gnt_vld[o]) begin
            r_out_flit[o] <= w_head[w_gnt_idx[o]];
            r_ptr[o]      <= wrap_dir(int'(w_gnt_idx[o]) + 1);
          end
        end
      end
    end
  end

  assign o_in_busy   = w_full;
  assign o_out_valid = r_out_valid;
  assign o_out_flit  = r_out_flit;

  logic [WIN_LOG2-1:0] r_win;
  logic [CNT_W-1:0]    r_run;
  logic [CNT_W-1:0]    r_flit_counter;
  logic [2:0]          w_acc_cnt;
  logic [CNT_W:0]      w_sum;
  logic [CNT_W-1:0]    w_sum_sat;

  assign w_acc_cnt = popcount_dir(i_in_valid & ~w_full);
  assign w_sum     = {1'b0, r_run} + (CNT_W+1)'(w_acc_cnt);
  assign w_sum_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  // The last cycle of a window still counts toward that window's total.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_win          <= '0;
      r_run          <= '0;
      r_flit_counter <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (&r_win) begin
        r_flit_counter <= w_sum_sat;
        r_run          <= '0;
      end else begin
        r_run <= w_sum_sat;
      end
    end
  end

  assign o_flit_counter = r_flit_counter;

endmodule
